freq_gate_ctrl: RTL

Measurement sequencer for the frequency counter. Generates the gate window from the system clock, synchronizes and edge-detects the external input, counts rising edges inside the window and hands the result to the display/readout logic through a valid/ack handshake. It replaces the free-running one-second tick with a controlled, range-selectable measurement cycle.

---
 rtl/freq_gate_ctrl.sv | 225 ++++++++++++++++++++++
 1 files changed

// File: rtl/freq_gate_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : freq_gate_ctrl
// Purpose  : Measurement sequencer for the frequency counter. Builds a
//            range-selectable gate window from the system clock, synchronizes
//            and edge-detects the external input, counts rising edges inside
//            the window (saturating, with overflow flag) and presents the
//            result through a valid/ack handshake.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   CLK_HZ       system clock frequency; base gate length in cycles
//   CNT_W        edge-counter and result width
//   SYNC_STAGES  synchronizer depth on iSignal (values below 2 use 2)
// Ports
//   iClk        in   1      system clock, rising edge
//   irst        in   1      asynchronous active-low reset
//   iStart      in   1      start request, sampled only in IDLE
//   iSignal     in   1      asynchronous input under measurement
//   iRange      in   2      gate select: CLK_HZ / 10^iRange cycles
//   iAck        in   1      consumer accepts the result
//   oCount      out  CNT_W  latched edge count
//   oValid      out  1      oCount/oOverflow/oRange valid
//   oOverflow   out  1      count saturated during last gate
//   oRange      out  2      range used for the result in oCount
//   oGate       out  1      high during the gate window
//   oBusy       out  1      high in every state except IDLE
// Build option
//   FREQ_AUTORUN_EN  when defined, an acknowledged result re-arms the next
//                    measurement directly instead of returning to IDLE.
// ============================================================================
module freq_gate_ctrl #(
  parameter int CLK_HZ      = 50_000_000,
  parameter int CNT_W       = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic             iClk,
  input  logic             irst,
  input  logic             iStart,
  input  logic             iSignal,
  input  logic [1:0]       iRange,
  input  logic             iAck,
  output logic [CNT_W-1:0] oCount,
  output logic             oValid,
  output logic             oOverflow,
  output logic [1:0]       oRange,
  output logic             oGate,
  output logic             oBusy
);

  localparam int c_SYNC_N = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
  localparam int c_GATE_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;

  // Gate lengths per range; clamped to at least one cycle for tiny CLK_HZ.
  localparam int c_G0 = (CLK_HZ        >= 1) ? CLK_HZ        : 1;
  localparam int c_G1 = (CLK_HZ / 10   >= 1) ? CLK_HZ / 10   : 1;
  localparam int c_G2 = (CLK_HZ / 100  >= 1) ? CLK_HZ / 100  : 1;
  localparam int c_G3 = (CLK_HZ / 1000 >= 1) ? CLK_HZ / 1000 : 1;

  // Terminal value of the gate counter (counter runs 0..G-1).
  localparam logic [c_GATE_W-1:0] c_LAST0 = c_GATE_W'(c_G0 - 1);
  localparam logic [c_GATE_W-1:0] c_LAST1 = c_GATE_W'(c_G1 - 1);
  localparam logic [c_GATE_W-1:0] c_LAST2 = c_GATE_W'(c_G2 - 1);
  localparam logic [c_GATE_W-1:0] c_LAST3 = c_GATE_W'(c_G3 - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ARM      = 3'd1,
    S_GATE     = 3'd2,
    S_DONE     = 3'd3,
    S_WAIT_ACK = 3'd4
  } state_t;

  state_t r_state;
  state_t w_nextState;

  logic [c_SYNC_N-1:0] r_sync;
  logic                r_sigPrev;
  logic                w_rise;

  logic [1:0]          r_rangeSel;
  logic [c_GATE_W-1:0] r_gateCnt;
  logic [c_GATE_W-1:0] r_gateLast;
  logic                w_gateDone;
  logic [CNT_W-1:0]    r_edgeCnt;
  logic                r_edgeOvf;

  logic [CNT_W-1:0]    r_count;
  logic                r_valid;
  logic                r_overflow;
  logic [1:0]          r_rangeOut;

  function automatic logic [c_GATE_W-1:0] gateLastOf(input logic [1:0] sel);
    logic [c_GATE_W-1:0] v;
    case (sel)
      2'd0:    v = c_LAST0;
      2'd1:    v = c_LAST1;
      2'd2:    v = c_LAST2;
      default: v = c_LAST3;
    endcase
    return v;
  endfunction

  // --------------------------------------------------------------------------
  // Input synchronizer and rising-edge detector. The extra r_sigPrev stage
  // gives the total input latency of SYNC_STAGES+1 cycles to the counter.
  // --------------------------------------------------------------------------
  always_ff @(posedge iClk or negedge irst) begin
    if (!irst) begin
      r_sync    <= '0;
      r_sigPrev <= 1'b0;
    end else begin
      r_sync    <= {r_sync[c_SYNC_N-2:0], iSignal};
      r_sigPrev <= r_sync[c_SYNC_N-1];
    end
  end

  assign w_rise     = r_sync[c_SYNC_N-1] & ~r_sigPrev;
  assign w_gateDone = (r_gateCnt == r_gateLast);

  // --------------------------------------------------------------------------
  // Sequencer state register
  // --------------------------------------------------------------------------
  always_ff @(posedge iClk or negedge irst) begin
    if (!irst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_IDLE: begin
        if (iStart) begin
          w_nextState = S_ARM;
        end
      end
      S_ARM: begin
        w_nextState = S_GATE;
      end
      S_GATE: begin
        if (w_gateDone) begin
          w_nextState = S_DONE;
        end
      end
      S_DONE: begin
        w_nextState = S_WAIT_ACK;
      end
      S_WAIT_ACK: begin
        if (iAck) begin
`ifdef FREQ_AUTORUN_EN
          w_nextState = S_ARM;
`else
          w_nextState = S_IDLE;
`endif
        end
      end
      default: begin
        w_nextState = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Gate/edge counters and result registers
  // --------------------------------------------------------------------------
  always_ff @(posedge iClk or negedge irst) begin
    if (!irst) begin
      r_rangeSel <= 2'd0;
      r_gateCnt  <= '0;
      r_gateLast <= '0;
      r_edgeCnt  <= '0;
      r_edgeOvf  <= 1'b0;
      r_count    <= '0;
      r_valid    <= 1'b0;
      r_overflow <= 1'b0;
      r_rangeOut <= 2'd0;
    end else begin
      case (r_state)
        S_ARM: begin
          r_rangeSel <= iRange;
          r_gateLast <= gateLastOf(iRange);
          r_gateCnt  <= '0;
          r_edgeCnt  <= '0;
          r_edgeOvf  <= 1'b0;
        end
        S_GATE: begin
          r_gateCnt <= r_gateCnt + 1'b1;
          if (w_rise) begin
            // Counter sticks at all-ones; any further edge flags overflow.
            if (&r_edgeCnt) begin
              r_edgeOvf <= 1'b1;
            end else begin
              r_edgeCnt <= r_edgeCnt + 1'b1;
            end
          end
        end
        S_DONE: begin
          r_count    <= r_edgeCnt;
          r_overflow <= r_edgeOvf;
          r_rangeOut <= r_rangeSel;
          r_valid    <= 1'b1;
        end
        S_WAIT_ACK: begin
          if (iAck) begin
            r_valid <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign oCount    = r_count;
  assign oValid    = r_valid;
  assign oOverflow = r_overflow;
  assign oRange    = r_rangeOut;
  assign oGate     = (r_state == S_GATE);
  assign oBusy     = (r_state != S_IDLE);

endmodule
`default_nettype wire
